// File: rtl/serial_tx_multilane_if.sv
// rtl/serial_tx_multilane_if.sv - word handshake and serial line bundle for serial_tx_multilane
//
// Purpose: carries the word-side Valid/Ready handshake and the serial-side
//          outputs of serial_tx_multilane between the router port and the link.
// Signals:
//   TX_Data        payload word, DATA_W bits        (master -> slave)
//   TX_Data_Valid  TX_Data holds a word to send     (master -> slave)
//   TX_Ready       transmitter can take a word      (slave -> master)
//   S_Data         serial lines, LANES bits         (slave -> master)
//   TX_Busy        a frame is on the lines          (slave -> master)
//   Fifo_Count     words currently buffered         (slave -> master)
interface serial_tx_multilane_if #(
  parameter int DATA_W     = 55,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 2
) ();

  logic [DATA_W-1:0]             TX_Data;
  logic                          TX_Data_Valid;
  logic                          TX_Ready;
  logic [LANES-1:0]              S_Data;
  logic                          TX_Busy;
  logic [$clog2(FIFO_DEPTH):0]   Fifo_Count;

  modport master (
    output TX_Data,
    output TX_Data_Valid,
    input  TX_Ready,
    input  S_Data,
    input  TX_Busy,
    input  Fifo_Count
  );

  modport slave (
    input  TX_Data,
    input  TX_Data_Valid,
    output TX_Ready,
    output S_Data,
    output TX_Busy,
    output Fifo_Count
  );

endinterface

// File: rtl/serial_tx_multilane.sv
// rtl/serial_tx_multilane.sv - FIFO-buffered multi-lane serial frame transmitter
//
// Purpose: buffers DATA_W-bit words in a FIFO_DEPTH-entry FIFO and sends each
//          one as a frame on LANES parallel lines: one all-ones start beat,
//          BEATS = ceil(DATA_W/LANES) data beats (lane k of beat b carries
//          bit b*LANES+k, bits past DATA_W sent as 0), an optional even-parity
//          beat per lane, then IDLE_GAP all-zero beats.
//          Example, DATA_W=55 LANES=4, all-ones word: 14 data beats,
//          beat 13 = 4'b0111, parity beat = 4'b1000 (lanes 0-2 carry 14 ones,
//          lane 3 carries 13 ones).
// Ports:
//   Clk_S  in  single clock, rising edge
//   Rst    in  synchronous reset, active high; aborts any frame in progress
//   tx     slave side of serial_tx_multilane_if (TX_Data, TX_Data_Valid,
//          TX_Ready, S_Data, TX_Busy, Fifo_Count)
module serial_tx_multilane #(
  parameter int DATA_W     = 55,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 2,
  parameter int PARITY_EN  = 1,
  parameter int IDLE_GAP   = 1
) (
  input logic                  Clk_S,
  input logic                  Rst,
  serial_tx_multilane_if.slave tx
);

  localparam int BEATS  = (DATA_W + LANES - 1) / LANES;
  localparam int SHW    = BEATS * LANES;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int CNTW_D = $clog2(BEATS + 1);
  localparam int CNTW_G = $clog2(IDLE_GAP + 1);
  // Wide enough for the longer of the data run and the idle gap.
  localparam int CNTW   = (CNTW_D > CNTW_G) ? CNTW_D : CNTW_G;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              fifo_nonempty;

  assign fifo_nonempty = (count != '0);
  assign tx.TX_Ready   = (count != CW'(FIFO_DEPTH));
  assign tx.Fifo_Count = count;
  assign push          = tx.TX_Data_Valid && tx.TX_Ready;

  always_ff @(posedge Clk_S) begin
    if (push) begin
      mem[wr_ptr] <= tx.TX_Data;
    end
  end

  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------- serialiser
  state_t            state;
  logic [CNTW-1:0]   beat_cnt;
  logic [SHW-1:0]    shreg;
  logic [LANES-1:0]  par_acc;
  logic [LANES-1:0]  s_data_q;
  logic              busy_q;
  logic [LANES-1:0]  chunk;
  logic              last_data;
  logic              last_gap;

  assign chunk      = shreg[LANES-1:0];
  assign last_data  = (beat_cnt == CNTW'(BEATS - 1));
  assign last_gap   = (beat_cnt == CNTW'(IDLE_GAP - 1));
  assign tx.S_Data  = s_data_q;
  assign tx.TX_Busy = busy_q;

  // A pop always launches the next frame on the following beat, so it is
  // taken one beat early wherever the frame can chain without an IDLE beat.
  always_comb begin
    pop = 1'b0;
    if (fifo_nonempty) begin
      case (state)
        S_IDLE:   pop = 1'b1;
        S_DATA:   pop = last_data && (PARITY_EN == 0) && (IDLE_GAP == 0);
        S_PARITY: pop = (IDLE_GAP == 0);
        S_GAP:    pop = last_gap;
        default:  pop = 1'b0;
      endcase
    end
  end

  // S_Data and TX_Busy are loaded with the value of the state being entered,
  // so they line up with the state register on the following cycle.
  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      shreg    <= '0;
      par_acc  <= '0;
      s_data_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      beat_cnt <= '0;
      if (pop) begin
        state    <= S_START;
        shreg    <= SHW'(mem[rd_ptr]);
        s_data_q <= '1;
        busy_q   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            s_data_q <= '0;
            busy_q   <= 1'b0;
          end
          S_START: begin
            state    <= S_DATA;
            s_data_q <= chunk;
            par_acc  <= chunk;
            shreg    <= shreg >> LANES;
          end
          S_DATA: begin
            if (!last_data) begin
              beat_cnt <= beat_cnt + 1'b1;
              s_data_q <= chunk;
              par_acc  <= par_acc ^ chunk;
              shreg    <= shreg >> LANES;
            end else if (PARITY_EN != 0) begin
              state    <= S_PARITY;
              s_data_q <= par_acc;
            end else if (IDLE_GAP != 0) begin
              state    <= S_GAP;
              s_data_q <= '0;
            end else begin
              state    <= S_IDLE;
              s_data_q <= '0;
              busy_q   <= 1'b0;
            end
          end
          S_PARITY: begin
            s_data_q <= '0;
            if (IDLE_GAP != 0) begin
              state <= S_GAP;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end
          S_GAP: begin
            s_data_q <= '0;
            if (!last_gap) begin
              beat_cnt <= beat_cnt + 1'b1;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end
          default: begin
            state    <= S_IDLE;
            s_data_q <= '0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_multilane.sv
// tb/tb_serial_tx_multilane.sv - self-checking bench for serial_tx_multilane
module tb_serial_tx_multilane;

  localparam int MAXC = 4096;
  localparam int DW   = 55;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] drv_data [2];
  logic          drv_valid [2];

  serial_tx_multilane_if #(.DATA_W(DW), .LANES(1), .FIFO_DEPTH(2)) bus0 ();
  serial_tx_multilane_if #(.DATA_W(DW), .LANES(4), .FIFO_DEPTH(2)) bus1 ();

  serial_tx_multilane #(.DATA_W(DW), .LANES(1), .FIFO_DEPTH(2), .PARITY_EN(1), .IDLE_GAP(1)) dut0 (
    .Clk_S (clk),
    .Rst   (rst),
    .tx    (bus0)
  );

  serial_tx_multilane #(.DATA_W(DW), .LANES(4), .FIFO_DEPTH(2), .PARITY_EN(1), .IDLE_GAP(0)) dut1 (
    .Clk_S (clk),
    .Rst   (rst),
    .tx    (bus1)
  );

  assign bus0.TX_Data       = drv_data[0];
  assign bus0.TX_Data_Valid = drv_valid[0];
  assign bus1.TX_Data       = drv_data[1];
  assign bus1.TX_Data_Valid = drv_valid[1];

  logic [3:0] obs_sd  [2];
  logic       obs_bz  [2];
  logic       obs_rdy [2];
  logic [1:0] obs_cnt [2];

  assign obs_sd[0]  = {3'b000, bus0.S_Data};
  assign obs_sd[1]  = bus1.S_Data;
  assign obs_bz[0]  = bus0.TX_Busy;
  assign obs_bz[1]  = bus1.TX_Busy;
  assign obs_rdy[0] = bus0.TX_Ready;
  assign obs_rdy[1] = bus1.TX_Ready;
  assign obs_cnt[0] = bus0.Fifo_Count;
  assign obs_cnt[1] = bus1.Fifo_Count;

  // Reference model: every accepted word is scheduled as a whole frame on a
  // per-cycle timeline of expected line values.
  logic [3:0] exp_sd [2][MAXC];
  bit         exp_bz [2][MAXC];
  bit         pop_at [2][MAXC];
  int         cnt_m  [2];
  int         last_s [2];
  int         cyc;
  int         n_chk;
  int         n_fail;

  function automatic int lanes_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic int gap_of(input int u);
    return (u == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      cnt_m[u]  = 0;
      last_s[u] = -100000;
      for (int c = cyc + 1; c < MAXC; c++) begin
        exp_sd[u][c] = 4'h0;
        exp_bz[u][c] = 1'b0;
        pop_at[u][c] = 1'b0;
      end
    end
  endtask

  task automatic model_push(input int u, input logic [DW-1:0] w);
    int ln, nb, gp, fl, s, idx;
    logic [3:0] beat, par;
    ln = lanes_of(u);
    nb = (DW + ln - 1) / ln;
    gp = gap_of(u);
    fl = nb + 2;
    s  = cyc + 2;
    if (last_s[u] + fl + gp > s) s = last_s[u] + fl + gp;
    last_s[u]       = s;
    pop_at[u][s-1]  = 1'b1;
    exp_sd[u][s]    = 4'((1 << ln) - 1);
    par = 4'h0;
    for (int b = 0; b < nb; b++) begin
      beat = 4'h0;
      for (int k = 0; k < ln; k++) begin
        idx = b * ln + k;
        if (idx < DW) beat[k] = w[idx];
      end
      par = par ^ beat;
      exp_sd[u][s+1+b] = beat;
    end
    exp_sd[u][s+1+nb] = par;
    for (int c = s; c < s + fl + gp; c++) exp_bz[u][c] = 1'b1;
  endtask

  task automatic step(input bit v0, input logic [DW-1:0] d0, input bit v1, input logic [DW-1:0] d1,
                      input bit r, output bit a0, output bit a1);
    drv_valid[0] = v0;
    drv_data[0]  = d0;
    drv_valid[1] = v1;
    drv_data[1]  = d1;
    rst          = r;
    a0 = v0 && !r && (cnt_m[0] != 2);
    a1 = v1 && !r && (cnt_m[1] != 2);
    if (r) begin
      model_reset();
    end else begin
      if (a0) model_push(0, d0);
      if (a1) model_push(1, d1);
      cnt_m[0] = cnt_m[0] + int'(a0) - int'(pop_at[0][cyc]);
      cnt_m[1] = cnt_m[1] + int'(a1) - int'(pop_at[1][cyc]);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    bit a0, a1;
    step(0, '0, 0, '0, 1, a0, a1);
    step(0, '0, 0, '0, 1, a0, a1);
    step(0, '0, 0, '0, 0, a0, a1);
    for (int u = 0; u < 2; u++) begin
      n_chk += 4;
      if (obs_sd[u] !== 4'h0) begin n_fail++; $display("FAIL reset s_data u%0d got %h expected 0", u, obs_sd[u]); end
      if (obs_bz[u] !== 1'b0) begin n_fail++; $display("FAIL reset busy u%0d got %b expected 0", u, obs_bz[u]); end
      if (obs_rdy[u] !== 1'b1) begin n_fail++; $display("FAIL reset ready u%0d got %b expected 1", u, obs_rdy[u]); end
      if (obs_cnt[u] !== 2'd0) begin n_fail++; $display("FAIL reset count u%0d got %0d expected 0", u, obs_cnt[u]); end
    end
  endtask

  task automatic test_single_frame();
    bit a0, a1;
    int a, bz0;
    a   = cyc;
    bz0 = 0;
    step(1, DW'(1), 1, {DW{1'b1}}, 0, a0, a1);
    for (int i = 0; i < 70; i++) begin
      for (int u = 0; u < 2; u++) begin
        n_chk += 4;
        if (obs_sd[u] !== exp_sd[u][cyc]) begin n_fail++; $display("FAIL single s_data u%0d cyc %0d got %h expected %h", u, cyc, obs_sd[u], exp_sd[u][cyc]); end
        if (obs_bz[u] !== exp_bz[u][cyc]) begin n_fail++; $display("FAIL single busy u%0d cyc %0d got %b expected %b", u, cyc, obs_bz[u], exp_bz[u][cyc]); end
        if (obs_rdy[u] !== (cnt_m[u] != 2)) begin n_fail++; $display("FAIL single ready u%0d cyc %0d got %b expected %b", u, cyc, obs_rdy[u], cnt_m[u] != 2); end
        if (obs_cnt[u] !== 2'(cnt_m[u])) begin n_fail++; $display("FAIL single count u%0d cyc %0d got %0d expected %0d", u, cyc, obs_cnt[u], cnt_m[u]); end
      end
      if (obs_bz[0] === 1'b1) bz0++;
      if (cyc == a + 2) begin
        n_chk++;
        if (obs_sd[0] !== 4'h1) begin n_fail++; $display("FAIL latency start beat got %h expected 1", obs_sd[0]); end
      end
      if (cyc == a + 58) begin
        n_chk++;
        if (obs_sd[0] !== 4'h1) begin n_fail++; $display("FAIL parity one-lane got %h expected 1", obs_sd[0]); end
      end
      if (cyc == a + 16) begin
        n_chk++;
        if (obs_sd[1] !== 4'b0111) begin n_fail++; $display("FAIL four-lane beat13 got %b expected 0111", obs_sd[1]); end
      end
      if (cyc == a + 17) begin
        n_chk++;
        if (obs_sd[1] !== 4'b1000) begin n_fail++; $display("FAIL four-lane parity got %b expected 1000", obs_sd[1]); end
      end
      step(0, '0, 0, '0, 0, a0, a1);
    end
    n_chk++;
    if (bz0 != 58) begin n_fail++; $display("FAIL busy length got %0d expected 58", bz0); end
  endtask

  task automatic test_fifo_full();
    bit a0, a1;
    logic [DW-1:0] w [4];
    int acc0, n;
    for (int k = 0; k < 4; k++) w[k] = rand_word();
    n    = 0;
    acc0 = -1000;
    for (int i = 0; i < 250; i++) begin
      step(n < 4, w[n & 3], 0, '0, 0, a0, a1);
      if (a0) begin
        if (n == 0) acc0 = cyc - 1;
        n++;
      end
      for (int u = 0; u < 2; u++) begin
        n_chk += 4;
        if (obs_sd[u] !== exp_sd[u][cyc]) begin n_fail++; $display("FAIL fifo_full s_data u%0d cyc %0d got %h expected %h", u, cyc, obs_sd[u], exp_sd[u][cyc]); end
        if (obs_bz[u] !== exp_bz[u][cyc]) begin n_fail++; $display("FAIL fifo_full busy u%0d cyc %0d got %b expected %b", u, cyc, obs_bz[u], exp_bz[u][cyc]); end
        if (obs_rdy[u] !== (cnt_m[u] != 2)) begin n_fail++; $display("FAIL fifo_full ready u%0d cyc %0d got %b expected %b", u, cyc, obs_rdy[u], cnt_m[u] != 2); end
        if (obs_cnt[u] !== 2'(cnt_m[u])) begin n_fail++; $display("FAIL fifo_full count u%0d cyc %0d got %0d expected %0d", u, cyc, obs_cnt[u], cnt_m[u]); end
      end
      if (cyc == acc0 + 3 || cyc == acc0 + 59) begin
        n_chk++;
        if (obs_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL fifo_full ready_low cyc %0d got %b expected 0", cyc, obs_rdy[0]); end
      end
      if (cyc == acc0 + 60) begin
        n_chk++;
        if (obs_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL fifo_full ready_back cyc %0d got %b expected 1", cyc, obs_rdy[0]); end
      end
    end
  endtask

  task automatic test_gap0_chain();
    bit a0, a1;
    int a;
    a = cyc;
    step(0, '0, 1, rand_word(), 0, a0, a1);
    step(0, '0, 1, rand_word(), 0, a0, a1);
    for (int i = 0; i < 40; i++) begin
      for (int u = 0; u < 2; u++) begin
        n_chk += 4;
        if (obs_sd[u] !== exp_sd[u][cyc]) begin n_fail++; $display("FAIL gap0 s_data u%0d cyc %0d got %h expected %h", u, cyc, obs_sd[u], exp_sd[u][cyc]); end
        if (obs_bz[u] !== exp_bz[u][cyc]) begin n_fail++; $display("FAIL gap0 busy u%0d cyc %0d got %b expected %b", u, cyc, obs_bz[u], exp_bz[u][cyc]); end
        if (obs_rdy[u] !== (cnt_m[u] != 2)) begin n_fail++; $display("FAIL gap0 ready u%0d cyc %0d got %b expected %b", u, cyc, obs_rdy[u], cnt_m[u] != 2); end
        if (obs_cnt[u] !== 2'(cnt_m[u])) begin n_fail++; $display("FAIL gap0 count u%0d cyc %0d got %0d expected %0d", u, cyc, obs_cnt[u], cnt_m[u]); end
      end
      if (cyc == a + 18) begin
        n_chk += 2;
        if (obs_sd[1] !== 4'hF) begin n_fail++; $display("FAIL gap0 chained start got %h expected f", obs_sd[1]); end
        if (obs_bz[1] !== 1'b1) begin n_fail++; $display("FAIL gap0 chained busy got %b expected 1", obs_bz[1]); end
      end
      step(0, '0, 0, '0, 0, a0, a1);
    end
  endtask

  task automatic test_reset_midframe();
    bit a0, a1;
    int a;
    a = cyc;
    step(1, rand_word(), 0, '0, 0, a0, a1);
    step(1, rand_word(), 0, '0, 0, a0, a1);
    for (int i = 0; i < 120; i++) begin
      step(cyc == a + 40, rand_word(), 0, '0, cyc == a + 23, a0, a1);
      for (int u = 0; u < 2; u++) begin
        n_chk += 4;
        if (obs_sd[u] !== exp_sd[u][cyc]) begin n_fail++; $display("FAIL midreset s_data u%0d cyc %0d got %h expected %h", u, cyc, obs_sd[u], exp_sd[u][cyc]); end
        if (obs_bz[u] !== exp_bz[u][cyc]) begin n_fail++; $display("FAIL midreset busy u%0d cyc %0d got %b expected %b", u, cyc, obs_bz[u], exp_bz[u][cyc]); end
        if (obs_rdy[u] !== (cnt_m[u] != 2)) begin n_fail++; $display("FAIL midreset ready u%0d cyc %0d got %b expected %b", u, cyc, obs_rdy[u], cnt_m[u] != 2); end
        if (obs_cnt[u] !== 2'(cnt_m[u])) begin n_fail++; $display("FAIL midreset count u%0d cyc %0d got %0d expected %0d", u, cyc, obs_cnt[u], cnt_m[u]); end
      end
      if (cyc == a + 24) begin
        n_chk += 3;
        if (obs_sd[0] !== 4'h0) begin n_fail++; $display("FAIL midreset after s_data got %h expected 0", obs_sd[0]); end
        if (obs_cnt[0] !== 2'd0) begin n_fail++; $display("FAIL midreset after count got %0d expected 0", obs_cnt[0]); end
        if (obs_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL midreset after ready got %b expected 1", obs_rdy[0]); end
      end
      if (cyc == a + 42) begin
        n_chk++;
        if (obs_sd[0] !== 4'h1) begin n_fail++; $display("FAIL midreset fresh start got %h expected 1", obs_sd[0]); end
      end
    end
  endtask

  task automatic test_valid_while_full();
    bit a0, a1;
    step(1, rand_word(), 0, '0, 0, a0, a1);
    step(1, rand_word(), 0, '0, 0, a0, a1);
    step(1, rand_word(), 0, '0, 0, a0, a1);
    n_chk += 2;
    if (obs_cnt[0] !== 2'd2) begin n_fail++; $display("FAIL blocked before count got %0d expected 2", obs_cnt[0]); end
    if (obs_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL blocked before ready got %b expected 0", obs_rdy[0]); end
    step(1, rand_word(), 0, '0, 0, a0, a1);
    n_chk++;
    if (obs_cnt[0] !== 2'd2) begin n_fail++; $display("FAIL blocked after count got %0d expected 2", obs_cnt[0]); end
    for (int i = 0; i < 200; i++) begin
      step(0, '0, 0, '0, 0, a0, a1);
      for (int u = 0; u < 2; u++) begin
        n_chk += 4;
        if (obs_sd[u] !== exp_sd[u][cyc]) begin n_fail++; $display("FAIL blocked s_data u%0d cyc %0d got %h expected %h", u, cyc, obs_sd[u], exp_sd[u][cyc]); end
        if (obs_bz[u] !== exp_bz[u][cyc]) begin n_fail++; $display("FAIL blocked busy u%0d cyc %0d got %b expected %b", u, cyc, obs_bz[u], exp_bz[u][cyc]); end
        if (obs_rdy[u] !== (cnt_m[u] != 2)) begin n_fail++; $display("FAIL blocked ready u%0d cyc %0d got %b expected %b", u, cyc, obs_rdy[u], cnt_m[u] != 2); end
        if (obs_cnt[u] !== 2'(cnt_m[u])) begin n_fail++; $display("FAIL blocked count u%0d cyc %0d got %0d expected %0d", u, cyc, obs_cnt[u], cnt_m[u]); end
      end
    end
  endtask

  task automatic test_random();
    bit a0, a1;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 2) == 0, rand_word(), $urandom_range(0, 2) == 0, rand_word(), 0, a0, a1);
      for (int u = 0; u < 2; u++) begin
        n_chk += 4;
        if (obs_sd[u] !== exp_sd[u][cyc]) begin n_fail++; $display("FAIL random s_data u%0d cyc %0d got %h expected %h", u, cyc, obs_sd[u], exp_sd[u][cyc]); end
        if (obs_bz[u] !== exp_bz[u][cyc]) begin n_fail++; $display("FAIL random busy u%0d cyc %0d got %b expected %b", u, cyc, obs_bz[u], exp_bz[u][cyc]); end
        if (obs_rdy[u] !== (cnt_m[u] != 2)) begin n_fail++; $display("FAIL random ready u%0d cyc %0d got %b expected %b", u, cyc, obs_rdy[u], cnt_m[u] != 2); end
        if (obs_cnt[u] !== 2'(cnt_m[u])) begin n_fail++; $display("FAIL random count u%0d cyc %0d got %0d expected %0d", u, cyc, obs_cnt[u], cnt_m[u]); end
      end
    end
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    cyc          = 0;
    rst          = 1'b1;
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
    drv_data[0]  = '0;
    drv_data[1]  = '0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_fifo_full();
    test_gap0_chain();
    test_reset_midframe();
    test_valid_while_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
